// File: rtl/edge_trigger_pkg.sv
// Shared definitions for the edge trigger bank.
//   EDGE_OFF/RISE/FALL/BOTH : 2-bit per-channel edge mode encodings
//   db_state_e               : debounce state (STABLE / SETTLING)
//   EVT_CNT_W                : width of each per-channel event counter
//   edge_qualifies()         : does a level toggle count as an event for a mode
package edge_trigger_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } db_state_e;

    localparam int EVT_CNT_W = 8;

    // rising = 1 for a 0->1 toggle of the debounced level, 0 for 1->0.
    function automatic logic edge_qualifies(input logic [1:0] mode, input logic rising);
        return rising ? |(mode & EDGE_RISE) : |(mode & EDGE_FALL);
    endfunction

endpackage

// File: rtl/edge_trigger_chan.sv
// One channel of the edge trigger bank: synchroniser, debounce FSM, edge
// qualification, sticky pending flag and (optionally) a saturating event counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   signal_in    : raw asynchronous input
//   edge_mode    : 00 off, 01 rise, 10 fall, 11 both
//   clr          : write-1-to-clear of pending (and the event counter)
//   level        : debounced level
//   triggered    : one-cycle pulse per qualified edge
//   pending      : sticky event flag
//   event_count  : saturating event counter, only built when EDGE_TRIGGER_COUNT_EN
//                  is defined; otherwise tied to 0
module edge_trigger_chan
    import edge_trigger_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal_in,
    input  logic [1:0]           edge_mode,
    input  logic                 clr,
    output logic                 level,
    output logic                 triggered,
    output logic                 pending,
    output logic [EVT_CNT_W-1:0] event_count
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    // The toggle happens on the DB_CYCLES-th differing sample, i.e. when the
    // counter already holds DB_CYCLES-1, so the counter never reaches its wrap.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   trig_q, trig_d;
    logic                   pend_q, pend_d;
    logic                   sync_s;
    db_state_e              state;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The debounce state is not stored: it is implied by whether the
    // synchronised sample disagrees with the current debounced level.
    assign state = (sync_s != level_q) ? SETTLING : STABLE;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        trig_d  = 1'b0;
        case (state)
            STABLE: begin
                cnt_d = '0;
            end
            SETTLING: begin
                if (cnt_q == DB_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                    trig_d  = edge_qualifies(edge_mode, ~level_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
        // A new event wins over a simultaneous clear.
        pend_d = trig_q | (pend_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            trig_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_in};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            trig_q  <= trig_d;
            pend_q  <= pend_d;
        end
    end

    assign level     = level_q;
    assign triggered = trig_q;
    assign pending   = pend_q;

`ifdef EDGE_TRIGGER_COUNT_EN
    logic [EVT_CNT_W-1:0] evt_q, evt_d;

    always_comb begin
        evt_d = evt_q;
        if (trig_q && clr) begin
            // Clear and a new event together leave exactly that event counted.
            evt_d = EVT_CNT_W'(1);
        end else if (trig_q) begin
            if (evt_q != '1) begin
                evt_d = evt_q + EVT_CNT_W'(1);
            end
        end else if (clr) begin
            evt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign event_count = evt_q;
`else
    assign event_count = '0;
`endif

endmodule

// File: rtl/edge_trigger_bank.sv
// Multi-channel edge trigger bank: CH independent edge_trigger_chan instances
// plus the any_pending summary.
// Optional feature macro: EDGE_TRIGGER_COUNT_EN (per-channel saturating event
// counters on event_count; when undefined event_count reads 0).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   signal_in    : CH raw asynchronous inputs
//   edge_mode    : 2 bits per channel at [2i+1:2i]
//   clr          : per-channel write-1-to-clear
//   level        : per-channel debounced level
//   triggered    : per-channel one-cycle event pulse
//   pending      : per-channel sticky event flag
//   any_pending  : OR of pending
//   event_count  : 8 bits per channel at [8i+:8]
module edge_trigger_bank
    import edge_trigger_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH-1:0]           signal_in,
    input  logic [2*CH-1:0]         edge_mode,
    input  logic [CH-1:0]           clr,
    output logic [CH-1:0]           level,
    output logic [CH-1:0]           triggered,
    output logic [CH-1:0]           pending,
    output logic                    any_pending,
    output logic [EVT_CNT_W*CH-1:0] event_count
);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            edge_trigger_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CYCLES   (DB_CYCLES)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .signal_in   (signal_in[gi]),
                .edge_mode   (edge_mode[2*gi +: 2]),
                .clr         (clr[gi]),
                .level       (level[gi]),
                .triggered   (triggered[gi]),
                .pending     (pending[gi]),
                .event_count (event_count[EVT_CNT_W*gi +: EVT_CNT_W])
            );
        end
    endgenerate

    assign any_pending = |pending;

endmodule

// File: tb/tb_edge_trigger_bank.sv
module tb_edge_trigger_bank;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int DB = 4;
    localparam int VW = 3*CH + 1 + 8*CH;

`ifdef EDGE_TRIGGER_COUNT_EN
    localparam int E_SAT = 255;
`else
    localparam int E_SAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   signal_in = '0;
    logic [2*CH-1:0] edge_mode = '0;
    logic [CH-1:0]   clr = '0;
    logic [CH-1:0]   level, triggered, pending;
    logic            any_pending;
    logic [8*CH-1:0] event_count;
    logic [VW-1:0]   obs;

    int total = 0;
    int bad   = 0;

    edge_trigger_bank #(.CH(CH), .SYNC_STAGES(S), .DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .signal_in   (signal_in),
        .edge_mode   (edge_mode),
        .clr         (clr),
        .level       (level),
        .triggered   (triggered),
        .pending     (pending),
        .any_pending (any_pending),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    assign obs = {level, triggered, pending, any_pending, event_count};

    // Reference model: s is the raw input delayed S edges; the level flips when
    // the last DB synchronised samples all differ from it.
    logic [CH-1:0] m_pipe [S];
    logic [CH-1:0] m_hist [DB];
    logic [CH-1:0] m_level = '0, m_trig = '0, m_pend = '0;
    int            m_cnt [CH];
    logic [VW-1:0] m_exp = '0;
    int            pcnt [CH];

    task automatic tick();
        logic [CH-1:0]   s_now, flip, nt;
        logic [8*CH-1:0] ev;
        @(posedge clk);
        if (rst) begin
            for (int j = 0; j < S; j++) m_pipe[j] = '0;
            for (int j = 0; j < DB; j++) m_hist[j] = '0;
            m_level = '0; m_trig = '0; m_pend = '0;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        end else begin
            s_now = m_pipe[S-1];
            for (int j = S-1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = signal_in;
            for (int j = DB-1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = s_now;
            flip = '1;
            for (int j = 0; j < DB; j++) flip &= (m_hist[j] ^ m_level);
            for (int i = 0; i < CH; i++) begin
                nt[i] = flip[i] && (m_level[i] ? edge_mode[2*i+1] : edge_mode[2*i]);
`ifdef EDGE_TRIGGER_COUNT_EN
                if (m_trig[i] && clr[i]) m_cnt[i] = 1;
                else if (m_trig[i])      m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
                else if (clr[i])         m_cnt[i] = 0;
`endif
            end
            m_pend  = m_trig | (m_pend & ~clr);
            m_trig  = nt;
            m_level = m_level ^ flip;
        end
        for (int i = 0; i < CH; i++) ev[8*i +: 8] = 8'(m_cnt[i]);
        m_exp = {m_level, m_trig, m_pend, |m_pend, ev};
        #1;
        for (int i = 0; i < CH; i++) if (triggered[i] === 1'b1) pcnt[i]++;
    endtask

    task automatic do_reset(input logic [CH-1:0] sig, input logic [2*CH-1:0] mode);
        signal_in = sig; edge_mode = mode; clr = '0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        for (int i = 0; i < CH; i++) pcnt[i] = 0;
    endtask

    task automatic test_reset();
        logic [CH-1:0] et;
        signal_in = '1; edge_mode = {2'b00, 2'b11, 2'b10, 2'b01}; clr = '0; rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick(); total++;
            if (obs !== '0) begin bad++; $display("FAIL reset_zero got=%h exp=0", obs); end
        end
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick(); total++;
            if (obs !== m_exp) begin bad++; $display("FAIL reset_model n=%0d got=%h exp=%h", n, obs, m_exp); end
            et = (n == 6) ? 4'b0101 : 4'b0000; total++;
            if (triggered !== et) begin bad++; $display("FAIL reset_release n=%0d got=%b exp=%b", n, triggered, et); end
        end
        $display("test_reset done");
    endtask

    task automatic test_glitch();
        do_reset('0, {2'b00, 2'b00, 2'b00, 2'b01});
        signal_in[0] = 1'b1;
        for (int n = 0; n < 14; n++) begin
            if (n == 3) signal_in[0] = 1'b0;
            tick(); total++;
            if (obs !== m_exp) begin bad++; $display("FAIL glitch3_model n=%0d got=%h exp=%h", n, obs, m_exp); end
        end
        total++;
        if (pcnt[0] !== 0 || level[0] !== 1'b0) begin
            bad++; $display("FAIL glitch3 pulses=%0d level=%b exp pulses=0 level=0", pcnt[0], level[0]);
        end
        signal_in[0] = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if (n == 4) signal_in[0] = 1'b0;
            tick(); total++;
            if (obs !== m_exp) begin bad++; $display("FAIL glitch4_model n=%0d got=%h exp=%h", n, obs, m_exp); end
        end
        total++;
        if (pcnt[0] !== 1 || level[0] !== 1'b0) begin
            bad++; $display("FAIL glitch4 pulses=%0d level=%b exp pulses=1 level=0", pcnt[0], level[0]);
        end
        $display("test_glitch done");
    endtask

    task automatic test_modes();
        logic [CH-1:0] el;
        do_reset('0, {2'b00, 2'b11, 2'b10, 2'b01});
        for (int h = 0; h < 4; h++) begin
            signal_in = (h % 2 == 0) ? '1 : '0;
            for (int n = 0; n < 20; n++) begin
                tick(); total++;
                if (obs !== m_exp) begin bad++; $display("FAIL modes_model h=%0d n=%0d got=%h exp=%h", h, n, obs, m_exp); end
            end
            el = (h % 2 == 0) ? '1 : '0; total++;
            if (level !== el) begin bad++; $display("FAIL modes_level h=%0d got=%b exp=%b", h, level, el); end
        end
        total++;
        if (pcnt[0] !== 2 || pcnt[1] !== 2 || pcnt[2] !== 4 || pcnt[3] !== 0) begin
            bad++; $display("FAIL modes_pulses got=%0d,%0d,%0d,%0d exp=2,2,4,0", pcnt[0], pcnt[1], pcnt[2], pcnt[3]);
        end
        $display("test_modes done");
    endtask

    task automatic test_pending();
        bit found = 0;
        do_reset('0, {2'b00, 2'b00, 2'b00, 2'b01});
        signal_in[0] = 1'b1;
        for (int n = 0; n < 11; n++) tick();
        total++;
        if (pending[0] !== 1'b1 || any_pending !== 1'b1) begin
            bad++; $display("FAIL pend_set got=%b/%b exp=1/1", pending[0], any_pending);
        end
        clr[0] = 1'b1; tick(); clr[0] = 1'b0; total++;
        if (pending[0] !== 1'b0 || any_pending !== 1'b0) begin
            bad++; $display("FAIL pend_clr got=%b/%b exp=0/0", pending[0], any_pending);
        end
        signal_in[0] = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        signal_in[0] = 1'b1;
        for (int n = 0; n < 20 && !found; n++) begin
            tick(); total++;
            if (obs !== m_exp) begin bad++; $display("FAIL pend_model n=%0d got=%h exp=%h", n, obs, m_exp); end
            if (triggered[0] === 1'b1) found = 1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL pend_timeout got=no_pulse exp=pulse");
        end else begin
            clr[0] = 1'b1; tick(); clr[0] = 1'b0; total++;
            if (pending[0] !== 1'b1) begin bad++; $display("FAIL pend_set_wins got=%b exp=1", pending[0]); end
        end
        $display("test_pending done");
    endtask

    task automatic test_mid_reset();
        logic et;
        do_reset('0, {2'b00, 2'b00, 2'b00, 2'b01});
        signal_in[0] = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        rst = 1'b1; tick(); rst = 1'b0; total++;
        if (triggered !== '0 || level !== '0) begin
            bad++; $display("FAIL midrst_discard got=%b/%b exp=0/0", triggered, level);
        end
        for (int n = 1; n <= 10; n++) begin
            tick(); et = (n == 6); total++;
            if (triggered[0] !== et) begin bad++; $display("FAIL midrst_latency n=%0d got=%b exp=%b", n, triggered[0], et); end
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_count();
        do_reset('0, {2'b00, 2'b00, 2'b00, 2'b01});
        for (int e = 0; e < 300; e++) begin
            signal_in[0] = 1'b1;
            for (int n = 0; n < 16; n++) begin
                if (n == 8) signal_in[0] = 1'b0;
                tick(); total++;
                if (obs !== m_exp) begin bad++; $display("FAIL count_model e=%0d got=%h exp=%h", e, obs, m_exp); end
            end
        end
        total++;
        if (event_count[7:0] !== 8'(E_SAT)) begin
            bad++; $display("FAIL count_sat got=%0d exp=%0d", event_count[7:0], E_SAT);
        end
        clr[0] = 1'b1; tick(); clr[0] = 1'b0; total++;
        if (event_count[7:0] !== 8'd0) begin bad++; $display("FAIL count_clr got=%0d exp=0", event_count[7:0]); end
        $display("test_count done");
    endtask

    task automatic test_random();
        int hold [CH];
        do_reset('0, 8'($urandom));
        for (int i = 0; i < CH; i++) hold[i] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    signal_in[i] = ~signal_in[i];
                    hold[i] = $urandom_range(1, 10);
                end
            end
            if (n % 250 == 0) edge_mode = 8'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
            rst = ($urandom_range(0, 499) == 0);
            tick(); total++;
            if (obs !== m_exp) begin bad++; $display("FAIL random_model n=%0d got=%h exp=%h", n, obs, m_exp); end
        end
        rst = 1'b0; clr = '0;
        $display("test_random done");
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin pcnt[i] = 0; m_cnt[i] = 0; end
        for (int j = 0; j < S; j++) m_pipe[j] = '0;
        for (int j = 0; j < DB; j++) m_hist[j] = '0;
        test_reset();
        test_glitch();
        test_modes();
        test_pending();
        test_mid_reset();
        test_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
